ov_vid_to_axis: RTL and testbench

- Downstream stage of the OV5640 capture wrapper, in the same CLK_i domain.
- Consumes its hs/vs/rgb888 stream, qualified by the vid_clk_ce pixel enable.
- Re-times pixels into an AXI4-Stream master: tuser = start of frame, tlast = end of line. The stream feeds the VDMA write channel.
- Small internal FIFO absorbs tready back-pressure; overflow drops the rest of the frame and resyncs on the next vsync.

---
 rtl/ov_vid_to_axis.sv | 168 ++++++++++++++++
 tb/tb_ov_vid_to_axis.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov_vid_to_axis.sv
// Re-times the capture wrapper's hs/vs/rgb pixel stream into an AXI4-Stream master through a FWFT FIFO.
// Optional: define OV_VID_FRAME_CNT_EN to add frame_cnt_o, a count of tuser handshakes.
module ov_vid_to_axis #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter logic        VS_POL     = 1'b1
) (
    input  logic              CLK_i,
    input  logic              rst_n_i,
    input  logic              vid_clk_ce_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic [DATA_W-1:0] rgb_i,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              overflow_o,
`ifdef OV_VID_FRAME_CNT_EN
    output logic [15:0]       frame_cnt_o,
`endif
    output logic [11:0]       line_len_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_W + 2;

    typedef enum logic [1:0] {StWaitVs, StWaitEnd, StActive, StDrop} state_e;
    state_e state_q, state_d;

    logic              stage_vld_q, stage_vld_d;
    logic [DATA_W-1:0] stage_data_q, stage_data_d;
    logic              stage_user_q, stage_user_d;
    logic              sof_pend_q, sof_pend_d;
    logic [11:0]       line_cnt_q, line_cnt_d;
    logic [11:0]       line_len_q, line_len_d;
    logic              overflow_q, overflow_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];

    logic          vs_act, push, push_last, push_drop, wr_en, rd_en, empty, full;
    logic [EW-1:0] rd_word;

    assign vs_act  = (vs_i == VS_POL);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en   = ~empty & m_axis_tready;
    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLK_i) begin
        if (!rst_n_i) begin
            state_q <= StWaitVs;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (vid_clk_ce_i) begin
            unique case (state_q)
                StWaitVs:  if (vs_act) state_d = StWaitEnd;
                StWaitEnd: if (!vs_act) state_d = StActive;
                StActive:  if (vs_act) state_d = StWaitEnd;
                StDrop:    if (vs_act) state_d = StWaitEnd;
                default:   state_d = StWaitVs;
            endcase
        end
        if (push_drop) state_d = StDrop;
    end

    // A staged pixel is only pushed once the next CE cycle tells us whether it ends the line.
    always_comb begin
        stage_vld_d  = stage_vld_q;
        stage_data_d = stage_data_q;
        stage_user_d = stage_user_q;
        sof_pend_d   = sof_pend_q;
        line_cnt_d   = line_cnt_q;
        push         = 1'b0;
        push_last    = 1'b0;
        if (vid_clk_ce_i) begin
            unique case (state_q)
                StWaitEnd: if (!vs_act) sof_pend_d = 1'b1;
                StActive: begin
                    if (vs_act || !hs_i) begin
                        push        = stage_vld_q;
                        push_last   = 1'b1;
                        stage_vld_d = 1'b0;
                    end else begin
                        push         = stage_vld_q;
                        stage_vld_d  = 1'b1;
                        stage_data_d = rgb_i;
                        stage_user_d = sof_pend_q;
                        sof_pend_d   = 1'b0;
                        if (!stage_vld_q) begin
                            line_cnt_d = 12'd1;
                        end else if (line_cnt_q != 12'hFFF) begin
                            line_cnt_d = line_cnt_q + 12'd1;
                        end
                    end
                end
                StDrop:  stage_vld_d = 1'b0;
                default: ;
            endcase
        end
        push_drop  = push & full & ~rd_en;
        wr_en      = push & ~push_drop;
        if (push_drop) stage_vld_d = 1'b0;
        overflow_d = overflow_q | push_drop;
        line_len_d = (wr_en && push_last) ? line_cnt_q : line_len_q;
        wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(rd_en);
    end

    always_comb begin
        m_axis_tvalid = ~empty;
        {m_axis_tuser, m_axis_tlast, m_axis_tdata} = empty ? '0 : rd_word;
        overflow_o    = overflow_q;
        line_len_o    = line_len_q;
    end

    always_ff @(posedge CLK_i) begin
        if (!rst_n_i) begin
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
            stage_user_q <= 1'b0;
            sof_pend_q   <= 1'b0;
            line_cnt_q   <= '0;
            line_len_q   <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            stage_vld_q  <= stage_vld_d;
            stage_data_q <= stage_data_d;
            stage_user_q <= stage_user_d;
            sof_pend_q   <= sof_pend_d;
            line_cnt_q   <= line_cnt_d;
            line_len_q   <= line_len_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (rst_n_i && wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {stage_user_q, push_last, stage_data_q};
        end
    end

`ifdef OV_VID_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_cnt_q + 16'(rd_en & m_axis_tuser);
    assign frame_cnt_o = frame_cnt_q;

    always_ff @(posedge CLK_i) begin
        if (!rst_n_i) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ov_vid_to_axis.sv
// Self-checking bench for ov_vid_to_axis: directed scenario table plus random frames against a
// frame-level model (pixels per line -> expected beats with tuser/tlast).
module tb_ov_vid_to_axis;
    localparam int   DW       = 24;
    localparam int   DEPTH    = 32;
    localparam logic VS_POL   = 1'b1;
    localparam int   RdyOn    = 0;
    localparam int   RdyRand  = 1;
    localparam int   RdyStall = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          hs = 1'b0;
    logic          vs = ~VS_POL;
    logic [DW-1:0] rgb = '0;
    logic          tready = 1'b1;
    logic [DW-1:0] tdata;
    logic          tvalid, tuser, tlast, overflow;
    logic [11:0]   line_len;
`ifdef OV_VID_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    always #5 clk = ~clk;

    ov_vid_to_axis #(
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH),
        .VS_POL    (VS_POL)
    ) dut (
        .CLK_i        (clk),
        .rst_n_i      (rst_n),
        .vid_clk_ce_i (ce),
        .hs_i         (hs),
        .vs_i         (vs),
        .rgb_i        (rgb),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tuser (tuser),
        .m_axis_tlast (tlast),
        .overflow_o   (overflow),
`ifdef OV_VID_FRAME_CNT_EN
        .frame_cnt_o  (frame_cnt),
`endif
        .line_len_o   (line_len)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    typedef struct {
        int nlines;
        int npix;
        int last_len;
        bit trunc;
        int ce_per;
        int rmode;
        bit exp_ovf;
        int exp_len;
    } row_t;

    beat_t exp_q[$];
    beat_t prev_beat;
    bit    prev_stall = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    ready_mode = RdyOn;
    int    exp_fc = 0;
    int    exp_len = 0;
    bit    exp_ovf = 1'b0;
    row_t  rows[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic monitor();
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("stall_valid", 64'(tvalid), 64'd1);
            check("stall_data", 64'(tdata), 64'(prev_beat.data));
            check("stall_user", 64'(tuser), 64'(prev_beat.user));
            check("stall_last", 64'(tlast), 64'(prev_beat.last));
        end
        if (tvalid === 1'b1 && tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data %0h expected no beat", tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 64'(tdata), 64'(e.data));
                check("beat_user", 64'(tuser), 64'(e.user));
                check("beat_last", 64'(tlast), 64'(e.last));
                if (e.user) exp_fc = (exp_fc + 1) % 65536;
            end
        end
        prev_stall     = (tvalid === 1'b1) && !tready;
        prev_beat.data = tdata;
        prev_beat.user = tuser;
        prev_beat.last = tlast;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        case (ready_mode)
            RdyOn:   tready = 1'b1;
            RdyRand: tready = ($urandom_range(3) != 0);
            default: tready = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ce = 1'b0;
        end
    endtask

    // CE=0 cycles carry junk on the video inputs; the DUT must ignore them.
    task automatic ce_cyc(input int per, input bit h, input bit act, input logic [DW-1:0] d);
        for (int i = 1; i < per; i++) begin
            tick();
            ce  = 1'b0;
            hs  = 1'($urandom);
            vs  = 1'($urandom);
            rgb = DW'($urandom);
        end
        tick();
        ce  = 1'b1;
        hs  = h;
        vs  = act ? VS_POL : ~VS_POL;
        rgb = d;
    endtask

    task automatic run_frame(input int nlines, input int npix, input int last_len, input bit trunc,
                             input int per, input int rmode);
        int            lens[$];
        logic [DW-1:0] pix[$];
        beat_t         beats[$];
        beat_t         b;
        int            run, k;
        for (int l = 0; l < nlines; l++) lens.push_back((l == nlines - 1) ? last_len : npix);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < lens[l]; p++) begin
                b.data = DW'($urandom);
                b.user = (l == 0 && p == 0);
                b.last = (p == lens[l] - 1);
                pix.push_back(b.data);
                beats.push_back(b);
            end
        end
        // Stalled output: only the first DEPTH pushes fit, the rest of the frame is lost.
        if (rmode == RdyStall && beats.size() > DEPTH) begin
            while (beats.size() > DEPTH) void'(beats.pop_back());
            exp_ovf = 1'b1;
        end
        run = 0;
        foreach (beats[i]) begin
            run++;
            if (beats[i].last) begin
                exp_len = run;
                run     = 0;
            end
            exp_q.push_back(beats[i]);
        end
        ready_mode = rmode;
        repeat (3) ce_cyc(per, 1'b0, 1'b1, DW'($urandom));
        repeat (2) ce_cyc(per, 1'b0, 1'b0, DW'($urandom));
        k = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < lens[l]; p++) begin
                ce_cyc(per, 1'b1, 1'b0, pix[k]);
                k++;
            end
            if (!(trunc && l == nlines - 1)) repeat (2) ce_cyc(per, 1'b0, 1'b0, DW'($urandom));
        end
        if (trunc) begin
            ce_cyc(per, 1'b1, 1'b1, DW'($urandom));
            repeat (2) ce_cyc(per, 1'b0, 1'b1, DW'($urandom));
        end
        idle(4);
    endtask

    task automatic drain();
        if (ready_mode == RdyStall) ready_mode = RdyOn;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
        check("drain_left", 64'(exp_q.size()), 64'd0);
        idle(4);
    endtask

    initial begin
        rows[0] = '{4, 8, 8, 1'b0, 2, RdyOn, 1'b0, 8};
        rows[1] = '{4, 8, 8, 1'b0, 1, RdyRand, 1'b0, 8};
        rows[2] = '{4, 8, 8, 1'b0, 2, RdyStall, 1'b0, 8};
        rows[3] = '{2, 40, 40, 1'b0, 1, RdyStall, 1'b1, 8};
        rows[4] = '{4, 8, 8, 1'b0, 2, RdyOn, 1'b1, 8};
        rows[5] = '{3, 8, 5, 1'b1, 2, RdyOn, 1'b1, 5};

        // Reset state.
        rst_n = 1'b0;
        idle(3);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_tuser", 64'(tuser), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_line_len", 64'(line_len), 64'd0);
`ifdef OV_VID_FRAME_CNT_EN
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        rst_n = 1'b1;

        // Mid-frame start: pixels without a preceding vsync are ignored.
        for (int l = 0; l < 3; l++) begin
            repeat (6) ce_cyc(2, 1'b1, 1'b0, DW'($urandom));
            repeat (2) ce_cyc(2, 1'b0, 1'b0, DW'($urandom));
        end
        idle(4);
        check("midframe_tvalid", 64'(tvalid), 64'd0);
        check("midframe_line_len", 64'(line_len), 64'd0);

        for (int r = 0; r < 6; r++) begin
            run_frame(rows[r].nlines, rows[r].npix, rows[r].last_len, rows[r].trunc,
                      rows[r].ce_per, rows[r].rmode);
            check($sformatf("row%0d_overflow", r), 64'(overflow), 64'(rows[r].exp_ovf));
            drain();
            check($sformatf("row%0d_line_len", r), 64'(line_len), 64'(rows[r].exp_len));
`ifdef OV_VID_FRAME_CNT_EN
            check($sformatf("row%0d_frame_cnt", r), 64'(frame_cnt), 64'(exp_fc));
`endif
        end

        // Reset in the middle of a stalled frame discards the FIFO.
        ready_mode = RdyStall;
        repeat (2) ce_cyc(2, 1'b0, 1'b1, DW'($urandom));
        repeat (2) ce_cyc(2, 1'b0, 1'b0, DW'($urandom));
        repeat (10) ce_cyc(2, 1'b1, 1'b0, DW'($urandom));
        idle(2);
        check("prerst_tvalid", 64'(tvalid), 64'd1);
        rst_n = 1'b0;
        idle(2);
        exp_fc  = 0;
        exp_len = 0;
        exp_ovf = 1'b0;
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_line_len", 64'(line_len), 64'd0);
`ifdef OV_VID_FRAME_CNT_EN
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        rst_n      = 1'b1;
        ready_mode = RdyOn;
        repeat (5) ce_cyc(2, 1'b1, 1'b0, DW'($urandom));
        repeat (2) ce_cyc(2, 1'b0, 1'b0, DW'($urandom));
        idle(4);
        check("postrst_tvalid", 64'(tvalid), 64'd0);

        // Random frames against the frame-level model.
        for (int f = 0; f < 12; f++) begin
            run_frame($urandom_range(1, 4), $urandom_range(1, 20), $urandom_range(1, 20),
                      ($urandom_range(3) == 0), $urandom_range(2, 4), RdyRand);
            check($sformatf("rand%0d_overflow", f), 64'(overflow), 64'(exp_ovf));
            drain();
            check($sformatf("rand%0d_line_len", f), 64'(line_len), 64'(exp_len));
`ifdef OV_VID_FRAME_CNT_EN
            check($sformatf("rand%0d_frame_cnt", f), 64'(frame_cnt), 64'(exp_fc));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
